// File: rtl/io_port_bridge.sv
// Host-side I/O bridge for the accumulator CPU: an input FIFO (host -> CPU IOIn)
// and an output FIFO (CPU Output -> host stream), with sticky underflow/overflow flags.
module io_port_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              reset,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_avail,
    input  logic              cpu_in_re,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_we,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    input  logic              clear_flags,
    output logic              underflow,
    output logic              overflow,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];

    logic [PTR_W-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
    logic [PTR_W-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [CNT_W-1:0] in_count_reg, out_count_reg;
    logic [CNT_W-1:0] in_count_next, out_count_next;
    logic             underflow_reg, overflow_reg;
    logic             underflow_next, overflow_next;

    logic in_full, in_empty, out_full, out_empty;
    logic in_push, in_pop, out_push, out_pop, out_drop, in_underrun;

    assign in_full   = (in_count_reg == FULL_CNT);
    assign in_empty  = (in_count_reg == '0);
    assign out_full  = (out_count_reg == FULL_CNT);
    assign out_empty = (out_count_reg == '0);

    assign in_push     = host_in_valid && !in_full;
    assign in_pop      = cpu_in_re && !in_empty;
    assign in_underrun = cpu_in_re && in_empty;

    // A full output FIFO still takes a CPU write when the host drains a word the same cycle.
    assign out_pop  = !out_empty && host_out_ready;
    assign out_push = cpu_out_we && (!out_full || out_pop);
    assign out_drop = cpu_out_we && out_full && !out_pop;

    always_comb begin
        in_count_next = in_count_reg;
        if (in_push && !in_pop)
            in_count_next = in_count_reg + CNT_W'(1);
        else if (!in_push && in_pop)
            in_count_next = in_count_reg - CNT_W'(1);

        out_count_next = out_count_reg;
        if (out_push && !out_pop)
            out_count_next = out_count_reg + CNT_W'(1);
        else if (!out_push && out_pop)
            out_count_next = out_count_reg - CNT_W'(1);

        // Set events take priority over a simultaneous clear.
        underflow_next = underflow_reg;
        if (in_underrun)
            underflow_next = 1'b1;
        else if (clear_flags)
            underflow_next = 1'b0;

        overflow_next = overflow_reg;
        if (out_drop)
            overflow_next = 1'b1;
        else if (clear_flags)
            overflow_next = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_wr_ptr_reg  <= '0;
            in_rd_ptr_reg  <= '0;
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            in_count_reg   <= '0;
            out_count_reg  <= '0;
            underflow_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (in_push)  in_wr_ptr_reg  <= in_wr_ptr_reg + PTR_W'(1);
            if (in_pop)   in_rd_ptr_reg  <= in_rd_ptr_reg + PTR_W'(1);
            if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + PTR_W'(1);
            if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + PTR_W'(1);
            in_count_reg  <= in_count_next;
            out_count_reg <= out_count_next;
            underflow_reg <= underflow_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Storage is not reset; the counts alone decide what is visible.
    always_ff @(posedge CLK) begin
        if (in_push)  in_mem[in_wr_ptr_reg]   <= host_in_data;
        if (out_push) out_mem[out_wr_ptr_reg] <= cpu_out_data;
    end

    assign cpu_in_data    = in_empty  ? '0 : in_mem[in_rd_ptr_reg];
    assign cpu_in_avail   = !in_empty;
    assign host_in_ready  = !in_full;
    assign host_out_data  = out_empty ? '0 : out_mem[out_rd_ptr_reg];
    assign host_out_valid = !out_empty;
    assign underflow      = underflow_reg;
    assign overflow       = overflow_reg;
    assign in_count       = in_count_reg;
    assign out_count      = out_count_reg;

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: a per-cycle queue scoreboard plus directed scenario checks.
module tb_io_port_bridge;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              CLK = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_avail;
    logic              cpu_in_re;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_we;
    logic [DATA_W-1:0] host_in_data;
    logic              host_in_valid;
    logic              host_in_ready;
    logic [DATA_W-1:0] host_out_data;
    logic              host_out_valid;
    logic              host_out_ready;
    logic              clear_flags;
    logic              underflow;
    logic              overflow;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_in[$];
    logic [DATA_W-1:0] m_out[$];
    logic m_uf = 1'b0;
    logic m_of = 1'b0;

    io_port_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_in_data(cpu_in_data), .cpu_in_avail(cpu_in_avail), .cpu_in_re(cpu_in_re),
        .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .clear_flags(clear_flags), .underflow(underflow), .overflow(overflow),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Mid-cycle scoreboard: compare against the model, then apply this cycle's inputs to it.
    always @(negedge CLK) begin
        if (!reset) begin
            m_in.delete();
            m_out.delete();
            m_uf = 1'b0;
            m_of = 1'b0;
        end else begin
            bit in_push, in_pop, out_push, out_pop;
            check("sb_in_cnt",  32'(in_count),  32'(m_in.size()));
            check("sb_out_cnt", 32'(out_count), 32'(m_out.size()));
            check("sb_in_rdy",  32'(host_in_ready), 32'(m_in.size() < DEPTH));
            check("sb_out_vld", 32'(host_out_valid), 32'(m_out.size() != 0));
            check("sb_uf", 32'(underflow), 32'(m_uf));
            check("sb_of", 32'(overflow),  32'(m_of));
            in_push  = host_in_valid && (m_in.size() < DEPTH);
            in_pop   = cpu_in_re && (m_in.size() != 0);
            out_pop  = host_out_ready && (m_out.size() != 0);
            out_push = cpu_out_we && ((m_out.size() < DEPTH) || out_pop);
            if (in_pop)
                check("sb_cpu_in", 32'(cpu_in_data), 32'(m_in.pop_front()));
            else if (m_in.size() == 0)
                check("sb_cpu_in_zero", 32'(cpu_in_data), 32'h0);
            if (out_pop)
                check("sb_host_out", 32'(host_out_data), 32'(m_out.pop_front()));
            else if (m_out.size() == 0)
                check("sb_host_out_zero", 32'(host_out_data), 32'h0);
            if (in_push)  m_in.push_back(host_in_data);
            if (out_push) m_out.push_back(cpu_out_data);
            if (cpu_in_re && !in_pop) m_uf = 1'b1;
            else if (clear_flags)     m_uf = 1'b0;
            if (cpu_out_we && !out_push) m_of = 1'b1;
            else if (clear_flags)        m_of = 1'b0;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_rdy"},  32'(host_in_ready),  32'h1);
        check({tag, "_out_vld"}, 32'(host_out_valid), 32'h0);
        check({tag, "_in_avail"},32'(cpu_in_avail),   32'h0);
        check({tag, "_in_data"}, 32'(cpu_in_data),    32'h0);
        check({tag, "_out_data"},32'(host_out_data),  32'h0);
        check({tag, "_in_cnt"},  32'(in_count),       32'h0);
        check({tag, "_out_cnt"}, 32'(out_count),      32'h0);
        check({tag, "_uf"},      32'(underflow),      32'h0);
        check({tag, "_of"},      32'(overflow),       32'h0);
    endtask

    initial begin
        logic [DATA_W-1:0] in_exp [4];
        reset = 1'b0;
        cpu_in_re = 0; cpu_out_we = 0; cpu_out_data = '0;
        host_in_data = '0; host_in_valid = 0; host_out_ready = 0; clear_flags = 0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check_reset_values("idle");

        // Fill the input FIFO, then hold a fifth word valid.
        host_in_valid = 1;
        host_in_data = 16'h1111; tick();
        host_in_data = 16'h2222; tick();
        host_in_data = 16'h3333; tick();
        host_in_data = 16'h4444; tick();
        host_in_data = 16'h5555;
        check("in_full_ready", 32'(host_in_ready), 32'h0);
        check("in_full_cnt", 32'(in_count), 32'h4);
        check("in_head_1", 32'(cpu_in_data), 32'h1111);
        cpu_in_re = 1; tick(); cpu_in_re = 0;
        check("ready_after_pop", 32'(host_in_ready), 32'h1);
        tick();
        host_in_valid = 0;
        check("in_refill_cnt", 32'(in_count), 32'h4);
        in_exp = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int i = 0; i < 4; i++) begin
            check("in_order", 32'(cpu_in_data), 32'(in_exp[i]));
            cpu_in_re = 1; tick();
        end
        cpu_in_re = 0;
        check("in_empty_avail", 32'(cpu_in_avail), 32'h0);
        check("in_empty_data", 32'(cpu_in_data), 32'h0);

        // Underflow and sticky-flag clear priority.
        cpu_in_re = 1; tick(); cpu_in_re = 0;
        check("uf_set", 32'(underflow), 32'h1);
        check("uf_cnt", 32'(in_count), 32'h0);
        clear_flags = 1; tick(); clear_flags = 0;
        check("uf_clear", 32'(underflow), 32'h0);
        clear_flags = 1; cpu_in_re = 1; tick(); clear_flags = 0; cpu_in_re = 0;
        check("uf_set_wins", 32'(underflow), 32'h1);
        clear_flags = 1; tick(); clear_flags = 0;

        // Output overflow with host stalled.
        host_out_ready = 0;
        cpu_out_we = 1;
        for (int i = 0; i < 5; i++) begin
            cpu_out_data = 16'hA000 + 16'(i); tick();
        end
        cpu_out_we = 0;
        check("of_cnt", 32'(out_count), 32'h4);
        check("of_set", 32'(overflow), 32'h1);
        check("out_head", 32'(host_out_data), 32'hA000);
        tick();
        check("out_stall_stable", 32'(host_out_data), 32'hA000);
        clear_flags = 1; tick(); clear_flags = 0;
        check("of_clear", 32'(overflow), 32'h0);
        host_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("out_drain", 32'(host_out_data), 32'hA000 + 32'(i));
            tick();
        end
        check("out_drained_vld", 32'(host_out_valid), 32'h0);
        host_out_ready = 0;

        // Full output FIFO with simultaneous pop and write.
        cpu_out_we = 1;
        for (int i = 0; i < 4; i++) begin
            cpu_out_data = 16'hB000 + 16'(i); tick();
        end
        host_out_ready = 1; cpu_out_data = 16'hBEEF; tick();
        cpu_out_we = 0;
        check("full_popwr_cnt", 32'(out_count), 32'h4);
        check("full_popwr_of", 32'(overflow), 32'h0);
        for (int i = 1; i < 4; i++) begin
            check("popwr_drain", 32'(host_out_data), 32'hB000 + 32'(i));
            tick();
        end
        check("popwr_last", 32'(host_out_data), 32'hBEEF);
        tick();
        check("popwr_empty", 32'(host_out_valid), 32'h0);
        host_out_ready = 0;

        // Asynchronous reset mid-stream.
        host_in_valid = 1; cpu_out_we = 1;
        host_in_data = 16'hC001; cpu_out_data = 16'hD001; tick();
        host_in_data = 16'hC002; cpu_out_data = 16'hD002; tick();
        host_in_valid = 0;
        cpu_out_data = 16'hD003; tick();
        cpu_out_we = 0;
        check("pre_rst_in_cnt", 32'(in_count), 32'h2);
        check("pre_rst_out_cnt", 32'(out_count), 32'h3);
        #2 reset = 1'b0;
        #1 check_reset_values("async_rst");
        tick();
        reset = 1'b1;
        tick(); tick();
        check_reset_values("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
